// File: rtl/bus_arb_pkg.sv
// Shared constants for the two-master data-memory arbiter: master ids,
// arbitration policy names and a constant-width helper.
package bus_arb_pkg;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  localparam string PRIO_FIXED = "FIXED";
  localparam string PRIO_RR    = "RR";

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_route_fifo.sv
// In-order FIFO of master ids for reads in flight; head is the owner of the next response.
// Registered state, combinational head; push is ignored when full, pop ignored when empty.
module rd_route_fifo
  import bus_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          srst,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_arb2.sv
// Two-master/one-slave arbiter with in-order read-response routing; request, ack and
// response paths are combinational. Reads stall while RD_DEPTH reads are outstanding.
module bus_arb2
  import bus_arb_pkg::*;
#(
  parameter string PRIO_MODE = PRIO_FIXED,
  parameter int    RD_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        srst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,
  output logic        err_o
);

  localparam int CW      = clog2(RD_DEPTH) + 1;
  localparam bit RR_MODE = (PRIO_MODE == PRIO_RR);

  logic [CW-1:0] rd_count;
  logic          fifo_full, fifo_empty, head_id;
  logic          push, pop;
  logic          elig0, elig1, lock_hold;
  logic          gnt_vld, gnt_id;
  logic          lock_vld_q, lock_vld_d;
  logic          lock_id_q, lock_id_d;
  logic          last_id_q, last_id_d;
  logic          err_q, err_d;

  rd_route_fifo #(.DEPTH(RD_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .srst  (srst),
    .push  (push),
    .pop   (pop),
    .din   (gnt_id),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rd_count)
  );

  // Full is the registered count: a same-cycle pop does not free a slot for a read.
  assign elig0     = m0_req_i & ~(~m0_we_i & fifo_full);
  assign elig1     = m1_req_i & ~(~m1_we_i & fifo_full);
  assign lock_hold = lock_vld_q & ((lock_id_q == MID_M1) ? elig1 : elig0);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = MID_M0;
    if (srst) begin
      gnt_vld = 1'b0;
    end else if (lock_hold) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else if (elig0 && elig1) begin
      gnt_vld = 1'b1;
      gnt_id  = RR_MODE ? ~last_id_q : MID_M0;
    end else if (elig0) begin
      gnt_vld = 1'b1;
      gnt_id  = MID_M0;
    end else if (elig1) begin
      gnt_vld = 1'b1;
      gnt_id  = MID_M1;
    end
  end

  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    if (gnt_vld) begin
      s_req_o    = 1'b1;
      s_we_o     = (gnt_id == MID_M1) ? m1_we_i     : m0_we_i;
      s_addr_bo  = (gnt_id == MID_M1) ? m1_addr_bi  : m0_addr_bi;
      s_be_bo    = (gnt_id == MID_M1) ? m1_be_bi    : m0_be_bi;
      s_wdata_bo = (gnt_id == MID_M1) ? m1_wdata_bi : m0_wdata_bi;
    end
  end

  assign m0_ack_o = gnt_vld & (gnt_id == MID_M0) & s_ack_i;
  assign m1_ack_o = gnt_vld & (gnt_id == MID_M1) & s_ack_i;

  assign push = gnt_vld & ~s_we_o & s_ack_i;
  assign pop  = s_resp_i & ~fifo_empty & ~srst;

  assign m0_resp_o   = pop & (head_id == MID_M0);
  assign m1_resp_o   = pop & (head_id == MID_M1);
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;
  assign err_o       = err_q;

  // Lock is recomputed each cycle: it survives only while the granted master waits unacked.
  always_comb begin
    lock_vld_d = gnt_vld & ~s_ack_i;
    lock_id_d  = gnt_vld ? gnt_id : lock_id_q;
    last_id_d  = (gnt_vld & s_ack_i) ? gnt_id : last_id_q;
    err_d      = err_q | (s_resp_i & (rd_count == '0));
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= MID_M0;
      last_id_q  <= MID_M1;
      err_q      <= 1'b0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      last_id_q  <= last_id_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_arb2.sv
// Directed bench for bus_arb2: FIXED and RR instances share stimulus; a monitor
// pops per-cycle expected observations from a scoreboard queue at the falling edge.
module tb_bus_arb2;

  typedef struct packed {
    logic        m0_ack;
    logic        m1_ack;
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        m0_resp;
    logic        m1_resp;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic        err;
  } obs_t;

  localparam logic [31:0] WD0 = 32'h0000_00A0;
  localparam logic [31:0] WD1 = 32'h0000_00B1;

  logic        clk = 1'b0;
  logic        srst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m1_addr;
  logic        s_ack, s_resp;
  logic [31:0] s_rdata;

  logic        f_m0_ack, f_m0_resp, f_m1_ack, f_m1_resp, f_s_req, f_s_we, f_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
  logic [3:0]  f_s_be;
  logic        r_m0_ack, r_m0_resp, r_m1_ack, r_m1_resp, r_s_req, r_s_we, r_err;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
  logic [3:0]  r_s_be;

  int    checks = 0;
  int    failures = 0;
  bit    sel_rr = 1'b0;
  obs_t  sb_q[$];
  string name_q[$];
  obs_t  obs_f, obs_r;

  always #5 clk = ~clk;

  bus_arb2 #(.PRIO_MODE("FIXED"), .RD_DEPTH(4)) dut_f (
    .clk_i(clk), .srst(srst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(4'hF), .m0_wdata_bi(WD0),
    .m0_ack_o(f_m0_ack), .m0_resp_o(f_m0_resp), .m0_rdata_bo(f_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(4'hF), .m1_wdata_bi(WD1),
    .m1_ack_o(f_m1_ack), .m1_resp_o(f_m1_resp), .m1_rdata_bo(f_m1_rdata),
    .s_req_o(f_s_req), .s_we_o(f_s_we), .s_addr_bo(f_s_addr), .s_be_bo(f_s_be), .s_wdata_bo(f_s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata), .err_o(f_err)
  );

  bus_arb2 #(.PRIO_MODE("RR"), .RD_DEPTH(4)) dut_rr (
    .clk_i(clk), .srst(srst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(4'hF), .m0_wdata_bi(WD0),
    .m0_ack_o(r_m0_ack), .m0_resp_o(r_m0_resp), .m0_rdata_bo(r_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(4'hF), .m1_wdata_bi(WD1),
    .m1_ack_o(r_m1_ack), .m1_resp_o(r_m1_resp), .m1_rdata_bo(r_m1_rdata),
    .s_req_o(r_s_req), .s_we_o(r_s_we), .s_addr_bo(r_s_addr), .s_be_bo(r_s_be), .s_wdata_bo(r_s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata), .err_o(r_err)
  );

  assign obs_f = '{f_m0_ack, f_m1_ack, f_s_req, f_s_we, f_s_addr, f_s_wdata,
                   f_m0_resp, f_m1_resp, f_m0_rdata, f_m1_rdata, f_err};
  assign obs_r = '{r_m0_ack, r_m1_ack, r_s_req, r_s_we, r_s_addr, r_s_wdata,
                   r_m0_resp, r_m1_resp, r_m0_rdata, r_m1_rdata, r_err};

  // g: 0 = nothing forwarded, 1 = master 0 forwarded, 2 = master 1 forwarded
  function automatic obs_t ex(bit a0, bit a1, int g, bit we, logic [31:0] addr,
                              bit r0, bit r1, logic [31:0] rd, bit err);
    obs_t e;
    e.m0_ack   = a0;
    e.m1_ack   = a1;
    e.s_req    = (g != 0);
    e.s_we     = (g != 0) ? we : 1'b0;
    e.s_addr   = (g != 0) ? addr : 32'h0;
    e.s_wdata  = (g == 1) ? WD0 : (g == 2) ? WD1 : 32'h0;
    e.m0_resp  = r0;
    e.m1_resp  = r1;
    e.m0_rdata = r0 ? rd : 32'h0;
    e.m1_rdata = r1 ? rd : 32'h0;
    e.err      = err;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      obs_t  e, o;
      string n;
      e = sb_q.pop_front();
      n = name_q.pop_front();
      o = sel_rr ? obs_r : obs_f;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, o, e);
      end
    end
  end

  task automatic step(input string n, input obs_t e);
    sb_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; s_ack = 0; s_resp = 0; s_rdata = 0;
  endtask

  initial begin
    srst = 1; m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0;
    idle();
    @(posedge clk);
    #1;
    // reset gates outputs even with live requests and responses
    m0_req = 1; m1_req = 1; s_ack = 1; s_resp = 1; s_rdata = 32'h55;
    step("reset_gate", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    srst = 0; idle();
    step("post_reset_idle", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_count", 32'(dut_rr.rd_count), 0);
    chk("rst_last_id", 32'(dut_rr.last_id_q), 1);

    // FIXED: simultaneous writes, m0 first then m1
    m0_req = 1; m0_we = 1; m0_addr = 32'h100;
    m1_req = 1; m1_we = 1; m1_addr = 32'h100; s_ack = 1;
    step("fixed_both_m0", ex(1, 0, 1, 1, 32'h100, 0, 0, 0, 0));
    m0_req = 0;
    step("fixed_m1_next", ex(0, 1, 2, 1, 32'h100, 0, 0, 0, 0));
    idle();

    // lock: m1 stalled by slave keeps the grant over higher-priority m0
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; s_ack = 0;
    step("lock_m1_first", ex(0, 0, 2, 1, 32'h200, 0, 0, 0, 0));
    m0_req = 1; m0_we = 1; m0_addr = 32'h100;
    step("lock_hold_1", ex(0, 0, 2, 1, 32'h200, 0, 0, 0, 0));
    step("lock_hold_2", ex(0, 0, 2, 1, 32'h200, 0, 0, 0, 0));
    s_ack = 1;
    step("lock_ack_m1", ex(0, 1, 2, 1, 32'h200, 0, 0, 0, 0));
    m1_req = 0;
    step("lock_then_m0", ex(1, 0, 1, 1, 32'h100, 0, 0, 0, 0));
    idle();

    // depth: four m1 reads fill the routing FIFO
    m1_req = 1; m1_we = 0; m1_addr = 32'h300; s_ack = 1;
    for (int i = 0; i < 4; i++) step("depth_rd", ex(0, 1, 2, 0, 32'h300, 0, 0, 0, 0));
    chk("depth_count_full", 32'(dut_f.rd_count), 4);
    m0_req = 1; m0_we = 1; m0_addr = 32'h100;
    step("depth_wr_passes", ex(1, 0, 1, 1, 32'h100, 0, 0, 0, 0));
    m0_req = 0;
    step("depth_rd_blocked", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    s_resp = 1; s_rdata = 32'hDEADBEEF;
    step("depth_resp_no_bypass", ex(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0));
    s_resp = 0;
    step("depth_rd5_accepted", ex(0, 1, 2, 0, 32'h300, 0, 0, 0, 0));
    m1_req = 0; s_resp = 1;
    for (int i = 1; i <= 4; i++) begin
      s_rdata = 32'(i);
      step("depth_drain", ex(0, 0, 0, 0, 0, 0, 1, 32'(i), 0));
    end
    idle();
    chk("depth_count_empty", 32'(dut_f.rd_count), 0);

    // push and pop in one cycle with two reads outstanding
    m0_req = 1; m0_we = 0; m0_addr = 32'h1000; s_ack = 1;
    step("pp_rd_m0", ex(1, 0, 1, 0, 32'h1000, 0, 0, 0, 0));
    m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 32'h300;
    step("pp_rd_m1", ex(0, 1, 2, 0, 32'h300, 0, 0, 0, 0));
    m1_req = 0; m0_req = 1; s_resp = 1; s_rdata = 32'h11;
    step("pp_push_pop", ex(1, 0, 1, 0, 32'h1000, 1, 0, 32'h11, 0));
    chk("pp_count_same", 32'(dut_f.rd_count), 2);
    m0_req = 0; s_rdata = 32'h22;
    step("pp_resp_m1", ex(0, 0, 0, 0, 0, 0, 1, 32'h22, 0));
    s_rdata = 32'h33;
    step("pp_resp_m0", ex(0, 0, 0, 0, 0, 1, 0, 32'h33, 0));
    idle();

    // fresh start for the round-robin instance
    srst = 1;
    step("reset2", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    srst = 0;
    sel_rr = 1'b1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h1000;
    m1_req = 1; m1_we = 0; m1_addr = 32'h2000; s_ack = 1;
    step("rr_g0", ex(1, 0, 1, 0, 32'h1000, 0, 0, 0, 0));
    step("rr_g1", ex(0, 1, 2, 0, 32'h2000, 0, 0, 0, 0));
    step("rr_g2", ex(1, 0, 1, 0, 32'h1000, 0, 0, 0, 0));
    step("rr_g3", ex(0, 1, 2, 0, 32'h2000, 0, 0, 0, 0));
    idle(); s_resp = 1;
    for (int i = 0; i < 4; i++) begin
      s_rdata = 32'h51 + 32'(i);
      step("rr_fifo_order", ex(0, 0, 0, 0, 0, (i % 2) == 0, (i % 2) == 1, 32'h51 + 32'(i), 0));
    end

    // response with nothing outstanding
    s_rdata = 32'h99;
    step("err_resp_dropped", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle();
    step("err_sticky", ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // reset with three reads in flight
    s_ack = 1; m0_req = 1;
    step("burst_m0", ex(1, 0, 1, 0, 32'h1000, 0, 0, 0, 1));
    m0_req = 0; m1_req = 1;
    step("burst_m1", ex(0, 1, 2, 0, 32'h2000, 0, 0, 0, 1));
    m1_req = 0; m0_req = 1;
    step("burst_m0b", ex(1, 0, 1, 0, 32'h1000, 0, 0, 0, 1));
    chk("burst_count", 32'(dut_rr.rd_count), 3);
    srst = 1; s_resp = 1; s_rdata = 32'h77;
    step("mid_reset", ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
    srst = 0; idle();
    step("after_reset", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("mid_rst_count", 32'(dut_rr.rd_count), 0);
    chk("mid_rst_last_id", 32'(dut_rr.last_id_q), 1);
    s_resp = 1; s_rdata = 32'h78;
    step("late_resp", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle();
    step("late_resp_err", ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
